// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line, one-entry
// holding register in front of the shift register for gap-free frames.
//
// Ports:
//   Clk         in   OVERSAMPLE x baud clock, rising edge
//   Reset       in   asynchronous, active-low
//   DataIn[7:0] in   byte to send, captured when Load is accepted
//   Load        in   write strobe, accepted when ReadyFlag=1
//   ReadyFlag   out  holding register empty
//   BusyFlag    out  frame in progress on Serout
//   DoneFlag    out  1-cycle pulse at the end of the last stop bit
//   OverrunFlag out  1-cycle pulse when a Load is dropped
//   Serout      out  serial line, idle 1

module uart_tx #(
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] DataIn,
   input  logic       Load,
   output logic       ReadyFlag,
   output logic       BusyFlag,
   output logic       DoneFlag,
   output logic       OverrunFlag,
   output logic       Serout
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [7:0] TMAX      = 8'(OVERSAMPLE - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [2:0] bit_ctr_q, bit_ctr_d;
   logic       stop_ctr_q, stop_ctr_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_valid_q, hold_valid_d;
   logic       serout_q, serout_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       overrun_q, overrun_d;

   logic       bit_end;
   logic       take;
   logic       load_ok;

   assign bit_end = (timer_q == 8'd0);
   assign load_ok = Load & ~hold_valid_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         timer_q      <= 8'd0;
         bit_ctr_q    <= 3'd0;
         stop_ctr_q   <= 1'b0;
         shift_q      <= 8'd0;
         hold_q       <= 8'd0;
         hold_valid_q <= 1'b0;
         serout_q     <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         bit_ctr_q    <= bit_ctr_d;
         stop_ctr_q   <= stop_ctr_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         serout_q     <= serout_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bit_ctr_d    = bit_ctr_q;
      stop_ctr_d   = stop_ctr_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      serout_d     = serout_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      overrun_d    = Load & hold_valid_q;
      take         = 1'b0;

      unique case (state_q)
         IDLE: begin
            serout_d = 1'b1;
            busy_d   = 1'b0;
            if (hold_valid_q) begin
               take = 1'b1;
            end
         end
         START: begin
            timer_d = timer_q - 8'd1;
            if (bit_end) begin
               timer_d   = TMAX;
               state_d   = DATA;
               serout_d  = shift_q[0];
               bit_ctr_d = 3'd7;
            end
         end
         DATA: begin
            timer_d = timer_q - 8'd1;
            if (bit_end) begin
               timer_d = TMAX;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_ctr_q == 3'd0) begin
                  state_d    = STOP;
                  serout_d   = 1'b1;
                  stop_ctr_d = 1'b0;
               end else begin
                  bit_ctr_d = bit_ctr_q - 3'd1;
                  serout_d  = shift_q[1];
               end
            end
         end
         STOP: begin
            timer_d = timer_q - 8'd1;
            if (bit_end) begin
               timer_d = TMAX;
               if (stop_ctr_q == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_valid_q) begin
                     take = 1'b1;
                  end else begin
                     state_d  = IDLE;
                     busy_d   = 1'b0;
                     serout_d = 1'b1;
                  end
               end else begin
                  stop_ctr_d = stop_ctr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Hand the held byte to the shifter and open the start bit.
      if (take) begin
         state_d      = START;
         shift_d      = hold_q;
         hold_valid_d = 1'b0;
         serout_d     = 1'b0;
         busy_d       = 1'b1;
         timer_d      = TMAX;
      end

      // load_ok and take are exclusive: take needs a full holding register.
      if (load_ok) begin
         hold_d       = DataIn;
         hold_valid_d = 1'b1;
      end
   end

   assign ReadyFlag   = ~hold_valid_q;
   assign BusyFlag    = busy_q;
   assign DoneFlag    = done_q;
   assign OverrunFlag = overrun_q;
   assign Serout      = serout_q;

endmodule
